// File: rtl/spi_adc_scanner.sv
// rtl/spi_adc_scanner.sv - round-robin SPI ADC channel scanner, optional 4-frame averaging via SPI_ADC_SCANNER_AVG_EN
module spi_adc_scanner #(
    parameter int DATA_W  = 12,
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 2,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              miso,
    output logic              mosi,
    output logic              sck,
    output logic              cs_n,
    output logic [DATA_W-1:0] sample_data,
    output logic [CH_W-1:0]   sample_ch,
    output logic              sample_valid,
    output logic              scan_done,
    output logic              busy
);

    // start + single-ended + channel + null + result bits
    localparam int FRAME_BITS = 3 + CH_W + DATA_W;
    localparam int CNT_W      = $clog2(CLK_DIV);
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SHIFT    = 3'd2,
        CS_HOLD  = 3'd3,
        GAP      = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic                    sck_q, sck_d;
    logic [FRAME_BITS-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]       rx_q, rx_d;
    logic [DATA_W-1:0]       sample_data_q, sample_data_d;
    logic [CH_W-1:0]         sample_ch_q, sample_ch_d;
    logic                    sample_valid_q, sample_valid_d;

    logic                    cnt_end;
    logic                    frame_done;
    logic                    advance;
    logic [FRAME_BITS-1:0]   cmd_word;

    // Command shifted out MSB first; the trailing result slots are driven low
    assign cmd_word = {2'b11, ch_q, 1'b0, {DATA_W{1'b0}}};
    assign cnt_end  = (cnt_q == CNT_LAST);

`ifdef SPI_ADC_SCANNER_AVG_EN
    logic [DATA_W+1:0] acc_q, acc_d;
    logic [1:0]        avg_q, avg_d;
    logic [DATA_W+1:0] acc_sum;

    assign acc_sum = acc_q + {2'b00, rx_q};
    // A channel is finished only once its fourth frame has been folded in
    assign advance = (avg_q == 2'd0);

    // Accumulator and per-channel frame counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            avg_q <= 2'd0;
        end else begin
            acc_q <= acc_d;
            avg_q <= avg_d;
        end
    end
`else
    assign advance = 1'b1;
`endif

    // State, timing counters, shift registers and sample outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            bit_q          <= '0;
            ch_q           <= '0;
            sck_q          <= 1'b0;
            tx_q           <= '0;
            rx_q           <= '0;
            sample_data_q  <= '0;
            sample_ch_q    <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bit_q          <= bit_d;
            ch_q           <= ch_d;
            sck_q          <= sck_d;
            tx_q           <= tx_d;
            rx_q           <= rx_d;
            sample_data_q  <= sample_data_d;
            sample_ch_q    <= sample_ch_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    // Next-state logic, SCK generation and sample capture
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bit_d          = bit_q;
        ch_d           = ch_q;
        sck_d          = 1'b0;
        tx_d           = tx_q;
        rx_d           = rx_q;
        sample_data_d  = sample_data_q;
        sample_ch_d    = sample_ch_q;
        sample_valid_d = 1'b0;
        frame_done     = 1'b0;
`ifdef SPI_ADC_SCANNER_AVG_EN
        acc_d          = acc_q;
        avg_d          = avg_q;
`endif

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (enable) begin
                    state_d = CS_SETUP;
                end
            end

            CS_SETUP: begin
                // Keep the command preloaded so MOSI is valid as SHIFT opens
                tx_d = cmd_word;
                if (cnt_end) begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            SHIFT: begin
                sck_d = sck_q;
                if (cnt_end) begin
                    cnt_d = '0;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        // Rising SCK: capture MISO; only the last DATA_W bits survive
                        rx_d = {rx_q[DATA_W-2:0], miso};
                    end else begin
                        // Falling SCK: present the next command bit
                        tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
                        if (bit_q == BIT_LAST) begin
                            bit_d      = '0;
                            state_d    = CS_HOLD;
                            frame_done = 1'b1;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            CS_HOLD: begin
                if (cnt_end) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            GAP: begin
                if (cnt_end) begin
                    cnt_d = '0;
                    if (!advance) begin
                        state_d = CS_SETUP;
                    end else if (ch_q == CH_LAST) begin
                        ch_d    = '0;
                        state_d = DONE;
                    end else begin
                        ch_d    = ch_q + 1'b1;
                        state_d = CS_SETUP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                state_d = enable ? CS_SETUP : IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (frame_done) begin
`ifdef SPI_ADC_SCANNER_AVG_EN
            if (avg_q == 2'd3) begin
                sample_data_d  = acc_sum[DATA_W+1:2];
                sample_ch_d    = ch_q;
                sample_valid_d = 1'b1;
                acc_d          = '0;
                avg_d          = 2'd0;
            end else begin
                acc_d = acc_sum;
                avg_d = avg_q + 2'd1;
            end
`else
            sample_data_d  = rx_q;
            sample_ch_d    = ch_q;
            sample_valid_d = 1'b1;
`endif
        end
    end

    assign cs_n         = !((state_q == CS_SETUP) || (state_q == SHIFT) || (state_q == CS_HOLD));
    assign sck          = sck_q;
    assign mosi         = (state_q == SHIFT) && tx_q[FRAME_BITS-1];
    assign sample_data  = sample_data_q;
    assign sample_ch    = sample_ch_q;
    assign sample_valid = sample_valid_q;
    assign scan_done    = (state_q == DONE);
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_spi_adc_scanner.sv
// tb/tb_spi_adc_scanner.sv - self-checking bench for spi_adc_scanner
module tb_spi_adc_scanner;

    localparam int DATA_W     = 12;
    localparam int NUM_CH     = 4;
    localparam int CH_W       = 2;
    localparam int CLK_DIV    = 4;
    localparam int FRAME_BITS = 3 + CH_W + DATA_W;
    localparam int HDR_W      = FRAME_BITS - DATA_W;
    localparam int FRAME_CYC  = 3 * CLK_DIV + 2 * CLK_DIV * FRAME_BITS;
`ifdef SPI_ADC_SCANNER_AVG_EN
    localparam int AVG_N = 4;
`else
    localparam int AVG_N = 1;
`endif

    logic              clk;
    logic              reset;
    logic              enable;
    logic              miso;
    logic              mosi;
    logic              sck;
    logic              cs_n;
    logic [DATA_W-1:0] sample_data;
    logic [CH_W-1:0]   sample_ch;
    logic              sample_valid;
    logic              scan_done;
    logic              busy;

    spi_adc_scanner #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_W(CH_W), .CLK_DIV(CLK_DIV)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .miso(miso), .mosi(mosi),
        .sck(sck), .cs_n(cs_n), .sample_data(sample_data), .sample_ch(sample_ch),
        .sample_valid(sample_valid), .scan_done(scan_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors;
    int checks;
    int cyc;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- ADC slave + reference model ----------------
    typedef struct packed { int ch; int data; } exp_t;
    exp_t exp_q[$];
    int   resp_q[$];

    int                    fcnt;
    int                    acc;
    int                    cur_ch;
    int                    rise_cnt;
    int                    hi_cnt;
    int                    low_cnt;
    bit                    in_frame;
    logic                  prev_cs;
    logic                  prev_sck;
    logic [FRAME_BITS-1:0] slave_word;
    logic [FRAME_BITS-1:0] mosi_word;
    logic [FRAME_BITS-1:0] exp_cmd;

    // Scans always begin at channel 0 and run to completion, so frame n since
    // reset converts channel (n / AVG_N) mod NUM_CH.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            resp_q.delete();
            fcnt = 0; acc = 0; in_frame = 0;
            prev_cs = 1'b1; prev_sck = 1'b0; miso = 1'b0;
        end else begin
            if (cs_n !== prev_cs) chk("cs_edge_sck_low", {63'd0, sck}, 64'd0);
            if (prev_cs && !cs_n) begin
                int v;
                if (resp_q.size() > 0) v = resp_q.pop_front();
                else v = int'($urandom_range(0, (1 << DATA_W) - 1));
                cur_ch     = (fcnt / AVG_N) % NUM_CH;
                slave_word = {HDR_W'($urandom), DATA_W'(v)};
                miso       = slave_word[FRAME_BITS-1];
                rise_cnt = 0; hi_cnt = 0; low_cnt = 0; mosi_word = '0; in_frame = 1;
                acc += v;
                if ((fcnt % AVG_N) == AVG_N - 1) begin
                    exp_q.push_back('{ch: cur_ch, data: acc / AVG_N});
                    acc = 0;
                end
                fcnt++;
            end
            if (!cs_n) low_cnt++;
            if (sck) hi_cnt++;
            if (!prev_sck && sck) begin
                mosi_word = {mosi_word[FRAME_BITS-2:0], mosi};
                rise_cnt++;
            end
            if (prev_sck && !sck && rise_cnt < FRAME_BITS)
                miso = slave_word[FRAME_BITS-1-rise_cnt];
            if (!prev_cs && cs_n && in_frame) begin
                exp_cmd = {2'b11, CH_W'(cur_ch), 1'b0, DATA_W'(0)};
                chk("frame_sck_rises", 64'(rise_cnt), 64'(FRAME_BITS));
                chk("frame_sck_high_cycles", 64'(hi_cnt), 64'(FRAME_BITS * CLK_DIV));
                chk("frame_cs_low_cycles", 64'(low_cnt), 64'(FRAME_CYC - CLK_DIV));
                chk("frame_mosi_bits", 64'(mosi_word), 64'(exp_cmd));
                in_frame = 0;
            end
            if (sample_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_sample_valid", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("model_sample_ch", 64'(sample_ch), 64'(e.ch));
                    chk("model_sample_data", 64'(sample_data), 64'(e.data));
                end
            end
            prev_cs  = cs_n;
            prev_sck = sck;
        end
    end

    // ---------------- directed table ----------------
    typedef struct packed {
        logic [15:0] v0, v1, v2, v3;
        logic [7:0]  exp_ch;
        logic [15:0] exp_data;
    } vec_t;
    vec_t tbl [8];

    task automatic set_vec(input int i, input int a, input int b, input int c, input int d,
                           input int ch, input int d_plain, input int d_avg);
        tbl[i].v0 = 16'(a); tbl[i].v1 = 16'(b); tbl[i].v2 = 16'(c); tbl[i].v3 = 16'(d);
        tbl[i].exp_ch = 8'(ch);
        tbl[i].exp_data = (AVG_N == 4) ? 16'(d_avg) : 16'(d_plain);
    endtask

    function automatic int vec_val(input vec_t v, input int k);
        case (k)
            0: return int'(v.v0);
            1: return int'(v.v1);
            2: return int'(v.v2);
            default: return int'(v.v3);
        endcase
    endfunction

    task automatic wait_valid(output int ch, output int data, output bit ok);
        ok = 0; ch = -1; data = -1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (sample_valid === 1'b1) begin
                ch = int'(sample_ch); data = int'(sample_data); ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL valid_timeout actual=none required=sample_valid");
        end
    endtask

    task automatic check_scan_end(input string tag, input bit restart);
        repeat (2 * CLK_DIV - 1) @(negedge clk);
        chk({tag, "_done_early"}, {63'd0, scan_done}, 64'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {63'd0, scan_done}, 64'd1);
        @(negedge clk);
        chk({tag, "_done_width"}, {63'd0, scan_done}, 64'd0);
        chk({tag, "_busy_after"}, {63'd0, busy}, {63'd0, restart});
        chk({tag, "_cs_n_after"}, {63'd0, cs_n}, {63'd0, !restart});
    endtask

    initial begin
        int  gch, gdata, last_t, t0, lows;
        bit  ok;
        errors = 0; checks = 0;
        reset = 1'b1; enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", {63'd0, cs_n}, 64'd1);
        chk("rst_sck", {63'd0, sck}, 64'd0);
        chk("rst_mosi", {63'd0, mosi}, 64'd0);
        chk("rst_sample_data", 64'(sample_data), 64'd0);
        chk("rst_sample_ch", 64'(sample_ch), 64'd0);
        chk("rst_sample_valid", {63'd0, sample_valid}, 64'd0);
        chk("rst_scan_done", {63'd0, scan_done}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        set_vec(0, 'h123, 'h123, 'h123, 'h123, 0, 'h123, 'h123);
        set_vec(1, 'hA5C, 'hA5C, 'hA5C, 'hA5C, 1, 'hA5C, 'hA5C);
        set_vec(2, 0, 0, 0, 3, 2, 0, 0);
        set_vec(3, 'hFFF, 'hFFF, 'hFFF, 'hFFE, 3, 'hFFF, 'hFFE);
        set_vec(4, 100, 101, 102, 103, 0, 100, 101);
        set_vec(5, 101, 7, 7, 7, 1, 101, 30);
        set_vec(6, 102, 0, 0, 0, 2, 102, 25);
        set_vec(7, 103, 1, 1, 1, 3, 103, 26);
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < AVG_N; k++) resp_q.push_back(vec_val(tbl[i], k));

        enable = 1'b1;
        last_t = 0;
        for (int r = 0; r < 8; r++) begin
            wait_valid(gch, gdata, ok);
            if (ok) begin
                chk($sformatf("tbl%0d_ch", r), 64'(gch), 64'(tbl[r].exp_ch));
                chk($sformatf("tbl%0d_data", r), 64'(gdata), 64'(tbl[r].exp_data));
                if (r > 0)
                    chk($sformatf("tbl%0d_spacing", r), 64'(cyc - last_t),
                        64'(FRAME_CYC * AVG_N + ((r == 4) ? 1 : 0)));
                last_t = cyc;
            end
            if (r == 3) check_scan_end("scan1", 1'b1);
            if (r == 4) begin
                repeat (20) @(negedge clk);
                enable = 1'b0;
            end
            if (r == 7) check_scan_end("scan2", 1'b0);
        end
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (!cs_n || busy) lows++;
        end
        chk("idle_stays_quiet", 64'(lows), 64'd0);

        // Reset in the middle of channel 2's shift phase
        enable = 1'b1;
        wait_valid(gch, gdata, ok);
        wait_valid(gch, gdata, ok);
        ok = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (!cs_n) begin ok = 1; break; end
        end
        chk("ch2_frame_start_seen", {63'd0, ok}, 64'd1);
        repeat (40) @(negedge clk);
        chk("mid_shift_cs_low", {63'd0, cs_n}, 64'd0);
        reset = 1'b1;
        #1;
        chk("arst_cs_n", {63'd0, cs_n}, 64'd1);
        chk("arst_sck", {63'd0, sck}, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_valid", {63'd0, sample_valid}, 64'd0);
        lows = 0;
        repeat (3) begin
            @(negedge clk);
            if (sample_valid) lows++;
        end
        chk("arst_no_valid", 64'(lows), 64'd0);
        reset = 1'b0;
        t0 = cyc;
        wait_valid(gch, gdata, ok);
        if (ok) begin
            chk("post_rst_first_ch", 64'(gch), 64'd0);
            chk("post_rst_latency", 64'(cyc - t0),
                64'(1 + CLK_DIV + 2 * CLK_DIV * FRAME_BITS + (AVG_N - 1) * FRAME_CYC));
        end

        // Randomized enable activity; the model checks every frame and sample
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            enable = ($urandom_range(0, 9) < 7);
        end
        enable = 1'b0;
        ok = 0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        chk("final_idle", {63'd0, ok}, 64'd1);
        repeat (5) @(negedge clk);
        chk("expected_samples_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
